// File: rtl/nes_palette_loader.sv
// Turns a streamed RGB888 NES palette file into 15-bit palette RAM writes.
// Tracks download completeness and ordering so the top level knows when the custom palette is usable.
module nes_palette_loader #(
    parameter logic [7:0]  PAL_INDEX = 8'd2,
    parameter int unsigned MIN_BYTES = 192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        load_color,
    output logic [14:0] load_color_data,
    output logic [5:0]  load_color_index,
    output logic        pal_valid,
    output logic        pal_error
);

    typedef enum logic [2:0] {
        StIdle,
        StGetR,
        StGetG,
        StGetB,
        StConvert,
        StWrite,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic        active_q;
    logic [10:0] cnt_q, cnt_d;
    logic [5:0]  entry_q, entry_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [14:0] data_q, data_d;
    logic [5:0]  index_q, index_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        order_err_q, order_err_d;

    logic        active, rise, fall, strobe, addr_ok, complete;
    logic [10:0] cnt_inc;

    // Round to nearest 5-bit level; anything that would round up to 32 saturates at 31.
    function automatic logic [4:0] to5(input logic [7:0] c);
        logic [8:0] s;
        s = {1'b0, c} + 9'd4;
        return s[8] ? 5'd31 : s[7:3];
    endfunction

    assign active   = ioctl_download & (ioctl_index == PAL_INDEX);
    assign rise     = active & ~active_q;
    assign fall     = ~active & active_q;
    assign strobe   = active & ioctl_wr;
    assign addr_ok  = (ioctl_addr == {14'd0, cnt_q});
    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign complete = (32'(cnt_q) >= MIN_BYTES) & ~order_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        entry_d     = entry_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        data_d      = data_q;
        index_d     = index_q;
        valid_d     = valid_q;
        error_d     = error_q;
        order_err_d = order_err_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d     = StGetR;
                    cnt_d       = 11'd0;
                    entry_d     = 6'd0;
                    valid_d     = 1'b0;
                    error_d     = 1'b0;
                    order_err_d = 1'b0;
                end
            end
            StGetR, StGetG, StGetB: begin
                if (strobe) begin
                    cnt_d = cnt_inc;
                    if (!addr_ok) begin
                        order_err_d = 1'b1;
                        error_d     = 1'b1;
                        state_d     = StDrain;
                    end else if (state_q == StGetR) begin
                        r_d     = ioctl_dout;
                        state_d = StGetG;
                    end else if (state_q == StGetG) begin
                        g_d     = ioctl_dout;
                        state_d = StGetB;
                    end else begin
                        b_d     = ioctl_dout;
                        state_d = StConvert;
                    end
                end
            end
            StConvert: begin
                data_d  = {to5(b_q), to5(g_q), to5(r_q)};
                index_d = entry_q;
                state_d = StWrite;
                if (strobe) order_err_d = 1'b1;
            end
            StWrite: begin
                entry_d = entry_q + 6'd1;
                state_d = (entry_q == 6'd63) ? StDrain : StGetR;
                if (strobe) order_err_d = 1'b1;
            end
            StDrain: begin
                if (strobe) begin
                    cnt_d = cnt_inc;
                    if (!addr_ok) begin
                        order_err_d = 1'b1;
                        error_d     = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // End of download wins over everything, including an in-flight write.
        if (fall && state_q != StIdle) begin
            state_d = StIdle;
            valid_d = complete;
            error_d = ~complete;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            active_q    <= 1'b0;
            cnt_q       <= 11'd0;
            entry_q     <= 6'd0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
            data_q      <= 15'd0;
            index_q     <= 6'd0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            data_q      <= data_d;
            index_q     <= index_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            order_err_q <= order_err_d;
        end
    end

    assign ioctl_wait       = (state_q == StConvert) || (state_q == StWrite);
    assign load_color       = (state_q == StWrite);
    assign load_color_data  = data_q;
    assign load_color_index = index_q;
    assign pal_valid        = valid_q;
    assign pal_error        = error_q;

endmodule

// File: tb/tb_nes_palette_loader.sv
// Randomized self-checking bench for nes_palette_loader.
// Expected palette writes and status come from a file-level model of the download.
module tb_nes_palette_loader;

    localparam logic [7:0] PAL = 8'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait, load_color, pal_valid, pal_error;
    logic [14:0] load_color_data;
    logic [5:0]  load_color_index;

    int errors = 0;
    int checks = 0;
    int last_base = 0;
    int run_len = 0;
    int max_run = 0;

    logic [7:0]  file_b [0:1535];
    int          cap_idx[$];
    logic [14:0] cap_data[$];

    nes_palette_loader #(.PAL_INDEX(PAL), .MIN_BYTES(192)) dut (
        .clk              (clk),
        .reset            (reset),
        .ioctl_download   (ioctl_download),
        .ioctl_index      (ioctl_index),
        .ioctl_wr         (ioctl_wr),
        .ioctl_addr       (ioctl_addr),
        .ioctl_dout       (ioctl_dout),
        .ioctl_wait       (ioctl_wait),
        .load_color       (load_color),
        .load_color_data  (load_color_data),
        .load_color_index (load_color_index),
        .pal_valid        (pal_valid),
        .pal_error        (pal_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_color) begin
            cap_idx.push_back(int'(load_color_index));
            cap_data.push_back(load_color_data);
            run_len = run_len + 1;
        end else begin
            run_len = 0;
        end
        if (run_len > max_run) max_run = run_len;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to5(input int c);
        int v;
        v = (c + 4) / 8;
        return (v > 31) ? 31 : v;
    endfunction

    function automatic logic [14:0] expect_color(input int e);
        int r, g, b;
        r = to5(int'(file_b[3*e]));
        g = to5(int'(file_b[3*e+1]));
        b = to5(int'(file_b[3*e+2]));
        return 15'(b * 1024 + g * 32 + r);
    endfunction

    // Drives one strobe; for a byte that completes an entry, checks the 2-cycle write latency.
    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input bit exp_wr,
                             input int gap);
        int n;
        int rest;
        n = 0;
        while (ioctl_wait && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("wait_bound", 32'(n), 32'd0);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        rest = gap - 1;
        if (exp_wr) begin
            check_eq("wait_c1", 32'(ioctl_wait), 32'd1);
            check_eq("lc_c1", 32'(load_color), 32'd0);
            @(negedge clk);
            check_eq("lc_c2", 32'(load_color), 32'd1);
            check_eq("wait_c2", 32'(ioctl_wait), 32'd1);
            rest = rest - 1;
        end
        repeat ((rest > 0) ? rest : 0) @(negedge clk);
    endtask

    // mode 0: entry n = (n, 2n, 3n); mode 1: random; mode 2: random with entry 0 = FF,04,03
    task automatic run_file(input int nbytes, input int skip, input int mode, input bit fixed_gap);
        int good, nwr, gap, got;
        bit exp_v;
        bit ew;
        logic [24:0] a;
        for (int i = 0; i < nbytes; i++)
            file_b[i] = (mode == 0) ? 8'(((i / 3) * ((i % 3) + 1)) % 256) : 8'($urandom);
        if (mode == 2) begin
            file_b[0] = 8'hFF;
            file_b[1] = 8'h04;
            file_b[2] = 8'h03;
        end
        good  = (skip < 0) ? nbytes : skip;
        nwr   = (good / 3 > 64) ? 64 : good / 3;
        exp_v = (skip < 0) && (nbytes >= 192);
        last_base = cap_idx.size();
        ioctl_index    = PAL;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            a   = (skip >= 0 && i >= skip) ? 25'(i + 1) : 25'(i);
            ew  = (i % 3 == 2) && (i / 3 < nwr);
            gap = fixed_gap ? 4 : int'($urandom_range(1, 4));
            send_byte(a, file_b[i], ew, gap);
        end
        repeat (6) @(negedge clk);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk);
        got = cap_idx.size() - last_base;
        check_eq("n_writes", 32'(got), 32'(nwr));
        for (int e = 0; e < nwr && e < got; e++) begin
            check_eq("w_index", 32'(cap_idx[last_base + e]), 32'(e));
            check_eq("w_data", 32'(cap_data[last_base + e]), 32'(expect_color(e)));
        end
        check_eq("pal_valid", 32'(pal_valid), 32'(exp_v));
        check_eq("pal_error", 32'(pal_error), 32'(!exp_v));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_eq("rst_wait", 32'(ioctl_wait), 32'd0);
        check_eq("rst_lc", 32'(load_color), 32'd0);
        check_eq("rst_data", 32'(load_color_data), 32'd0);
        check_eq("rst_index", 32'(load_color_index), 32'd0);
        check_eq("rst_valid", 32'(pal_valid), 32'd0);
        check_eq("rst_error", 32'(pal_error), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Canonical 192-byte file, one byte every 4 cycles.
        run_file(192, -1, 0, 1'b1);
        check_eq("entry5", 32'((cap_data.size() > last_base + 5) ? cap_data[last_base + 5] : 15'hx),
                 32'h0821);

        // Foreign download index must not disturb anything.
        base = cap_idx.size();
        ioctl_index    = 8'd5;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 30; i++) send_byte(25'(i), 8'($urandom), 1'b0, 2);
        check_eq("fx_wait", 32'(ioctl_wait), 32'd0);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("fx_writes", 32'(cap_idx.size() - base), 32'd0);
        check_eq("fx_valid", 32'(pal_valid), 32'd1);
        check_eq("fx_error", 32'(pal_error), 32'd0);

        // Rounding and saturation on entry 0.
        run_file(192, -1, 2, 1'b0);
        check_eq("round0", 32'((cap_data.size() > last_base) ? cap_data[last_base] : 15'hx),
                 32'h003F);

        run_file(1536, -1, 1, 1'b0);
        run_file(100, -1, 1, 1'b0);
        run_file(192, 10, 1, 1'b1);

        // Reset on the cycle after a B-byte strobe aborts the write.
        base = cap_idx.size();
        ioctl_index    = PAL;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(i * 7), (i % 3 == 2), 4);
        ioctl_addr = 25'd8;
        ioctl_dout = 8'h80;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        check_eq("ra_lc", 32'(load_color), 32'd0);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        @(negedge clk);
        check_eq("ra_lc_after", 32'(load_color), 32'd0);
        check_eq("ra_wait", 32'(ioctl_wait), 32'd0);
        check_eq("ra_data", 32'(load_color_data), 32'd0);
        check_eq("ra_index", 32'(load_color_index), 32'd0);
        check_eq("ra_valid", 32'(pal_valid), 32'd0);
        check_eq("ra_error", 32'(pal_error), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("ra_writes", 32'(cap_idx.size() - base), 32'd2);
        run_file(192, -1, 1, 1'b0);

        // Random lengths and contents.
        for (int k = 0; k < 3; k++) begin
            case ($urandom_range(0, 2))
                0:       run_file(int'($urandom_range(3, 191)), -1, 1, 1'b0);
                1:       run_file(int'($urandom_range(192, 400)), -1, 1, 1'b0);
                default: run_file(192, int'($urandom_range(0, 190)), 1, 1'b0);
            endcase
        end

        check_eq("lc_max_run", 32'(max_run), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
